// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle radix-2 restoring divider for DIV/DIVU.
//               One quotient bit per cycle. A result is presented as
//               {remainder, quotient} on hilo together with a one-cycle done
//               pulse. The EX stage is held via stall while the divide runs.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   pipeline clock, rising edge
//   rst          in   asynchronous active-low reset
//   start        in   divide request, sampled in IDLE only
//   is_signed    in   1 = DIV (two's complement), 0 = DIVU
//   dividend     in   numerator
//   divisor      in   denominator
//   cancel       in   abort current operation (flush/exception)
//   stall        out  pipeline hold: request accepted or iteration running
//   done         out  one-cycle pulse, hilo valid
//   hilo         out  {remainder, quotient}
//   div_by_zero  out  qualifies done: divisor of this result was zero
// ============================================================================
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               cancel,
  output logic               stall,
  output logic               done,
  output logic [2*WIDTH-1:0] hilo,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;      // partial remainder
  logic [WIDTH-1:0]     quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]     dvs_q, dvs_d;      // divisor magnitude
  logic [WIDTH-1:0]     dvd_q, dvd_d;      // raw dividend, returned as remainder on divide by zero
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 zero_q, zero_d;
  logic [2*WIDTH-1:0]   hilo_q, hilo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  // Operand magnitudes; raw operands when unsigned.
  logic                 w_dvd_neg, w_dvs_neg;
  logic [WIDTH-1:0]     w_dvd_mag, w_dvs_mag;

  assign w_dvd_neg = is_signed & dividend[WIDTH-1];
  assign w_dvs_neg = is_signed & divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
  assign w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;

  // One restoring step. The trial is WIDTH+1 bits wide; since the partial
  // remainder is always below the divisor, bit WIDTH is a true sign bit.
  logic [WIDTH:0]       w_rem_sh, w_trial;
  logic                 w_fit;
  logic [WIDTH-1:0]     w_rem_it, w_quo_it;
  logic [WIDTH-1:0]     w_rem_fin, w_quo_fin;

  assign w_rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, dvs_q};
  assign w_fit    = ~w_trial[WIDTH];
  assign w_rem_it = w_fit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_it = {quo_q[WIDTH-2:0], w_fit};

  // Final sign fix-up is folded into the last iteration so hilo and done
  // land on the edge that enters FINISH.
  assign w_quo_fin = zero_q ? {WIDTH{1'b1}} : (qneg_q ? (~w_quo_it + 1'b1) : w_quo_it);
  assign w_rem_fin = zero_q ? dvd_q         : (rneg_q ? (~w_rem_it + 1'b1) : w_rem_it);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    hilo_d  = hilo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = w_dvd_mag;
          dvs_d   = w_dvs_mag;
          dvd_d   = dividend;
          qneg_d  = w_dvd_neg ^ w_dvs_neg;
          rneg_d  = w_dvd_neg;
          zero_d  = (divisor == '0);
        end
      end
      CALC: begin
        rem_d = w_rem_it;
        quo_d = w_quo_it;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST) begin
          state_d = FINISH;
          hilo_d  = {w_rem_fin, w_quo_fin};
          done_d  = 1'b1;
          dbz_d   = zero_q;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything, including a same-cycle start.
    if (cancel) begin
      state_d = IDLE;
      hilo_d  = hilo_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      hilo_q  <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      hilo_q  <= hilo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Combinational in the start cycle so EX freezes immediately.
  assign stall       = ((state_q == IDLE) & start & ~cancel) | (state_q == CALC);
  assign done        = done_q;
  assign hilo        = hilo_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider that serves DIV/DIVU for the EX-stage ALU. It accepts one operation through a start/stall/done handshake and runs a radix-2 restoring iteration, one quotient bit per cycle. It returns a 64-bit HI/LO pair (remainder, quotient) that the ALU forwards as `hilo`. It holds the pipeline via `stall` until the result is ready.

## Interface
Parameters:
- `WIDTH`, 32: operand width; quotient and remainder are each `WIDTH` bits.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset; clears all state immediately when low.
- `start`  in  1  request a divide; sampled only in IDLE.
- `is_signed`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `dividend`  in  WIDTH  numerator (rs after forwarding); sampled with `start`.
- `divisor`  in  WIDTH  denominator (rt after forwarding); sampled with `start`.
- `cancel`  in  1  abort the in-flight operation (exception/flush from EX).
- `stall`  out  1  hold the pipeline; a divide is accepted or in progress.
- `done`  out  1  one-cycle pulse; `hilo` is valid this cycle.
- `hilo`  out  2*WIDTH  {remainder, quotient}; HI = [63:32], LO = [31:0].
- `div_by_zero`  out  1  qualifies `done`: the divisor of this result was 0.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE:
  - `start`=1 and `cancel`=0: latch |dividend|, |divisor|, the quotient sign (dividend[31]^divisor[31])&is_signed, the remainder sign dividend[31]&is_signed, and zero-flag (divisor==0). Clear partial remainder, clear count, go to CALC.
  - Magnitudes are computed only when `is_signed`=1; otherwise operands are used raw.
- CALC: each cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem_shifted − divisor_mag, computed at WIDTH+1 bits.
  - If trial ≥ 0: rem = trial and quo[0]=1; else quo[0]=0.
  - Count increments; after count reaches 31 (32 iterations), go to FINISH.
- FINISH:
  - Apply signs: quotient negated if its sign is 1; remainder negated if its sign is 1.
  - Register `hilo`, assert `done` and `div_by_zero` (zero-flag) for this one cycle, return to IDLE.
- Divide by zero: runs full latency. Result forced to quotient = all-ones and remainder = raw dividend, regardless of `is_signed`. `div_by_zero`=1.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0; no flag.
- `hilo` holds its last value in IDLE until the next FINISH.
- `start` while in CALC/FINISH is ignored; no queuing.
- `cancel` in any state: next state IDLE, no `done`, `hilo` unchanged. `cancel` in the same cycle as `start` in IDLE takes priority; the request is dropped.

## Timing
- Reset (`rst`=0): state IDLE, `stall`=0, `done`=0, `hilo`=0, `div_by_zero`=0, count=0.
- `stall` = (IDLE & start & ~cancel) | CALC. It is combinational in the start cycle so EX freezes the same cycle. It is 0 in FINISH, so the pipeline advances with `done`.
- Latency: `start` accepted at edge T0. CALC occupies cycles T1..T32. `done`=1 in cycle T33 (33 cycles after the start cycle). `stall` is high in cycles T0..T32 (33 cycles).
- `done` and `hilo` update at the same edge; `done` is never high for more than one consecutive cycle.
- Back-to-back: `start` in the cycle after FINISH is accepted normally. `start` during FINISH is ignored.
- `rst` asserted mid-operation: immediate IDLE, outputs to reset values, no `done`.
- Count wrap: the counter saturates by state exit; it is not reused past 31.

## Test plan
- DIVU 100 / 7:
  - `stall` rises in the start cycle.
  - `done` exactly 33 cycles later with `hilo`=0x00000002_0000000E, `div_by_zero`=0.
  - `hilo` is held after.
- DIV −7 / 2 (0xFFFFFFF9 / 0x00000002) -> `hilo`=0xFFFFFFFF_FFFFFFFD.
- DIV 7 / −2 -> `hilo`=0x00000001_FFFFFFFD.
- DIVU 0xFFFFFFFF / 0x00000001 -> `hilo`=0x00000000_FFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> `hilo`=0x00000000_80000000, `div_by_zero`=0.
- DIVU 0x1234 / 0 -> after 33 cycles, `hilo`=0x00001234_FFFFFFFF, `div_by_zero`=1 with `done`.
- Cancel and reset:
  - Start 100/7, pulse `cancel` at T10 -> `stall`=0 from T11, no `done`, `hilo` keeps its prior value.
  - Then start 9/3 -> `hilo`=0x00000000_00000003 after 33 cycles.
  - Separately, drop `rst` at T20 -> all outputs 0 immediately; a new start after release completes correctly.
